biquad_mc: RTL
==============

Name: biquad_mc

Overview:
Multi-channel, time-multiplexed biquad IIR filter that generalises the fixed single-channel highpass stage of the channel strip. It has parametrised channel count, data width and coefficient format. A selectable coefficient set covers bypass plus four highpass corners. A single shared multiplier, valid/ready framing, history clear on filter change and an explicit flush are also provided. It sits between the input deserialiser and the EQ stage, running on clk_144 with one sample frame (all channels) per handshake.

Parameters:
CHANNELS, 2, channels processed per frame (1..8)
DATA_W, 16, sample width, two's complement
COEF_W, 32, coefficient width, signed
FRAC, 30, coefficient fraction bits (Q(COEF_W-FRAC).FRAC)
GUARD, 4, extra integer bits kept in the y-history
CLEAR_ON_CHANGE, 1, 1 = zero all history when the latched filter select differs from the previous frame

Ports:
clk_144  in  1  system clock
reset  in  1  asynchronous, active-high reset
filter  in  3  coefficient set select, latched on input handshake
clear  in  1  flush request for all channel history
in_valid  in  1  input frame valid
in_ready  out  1  block can accept a frame
in_data  in  CHANNELS*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
out_valid  out  1  output frame valid
out_ready  in  1  downstream accepts the frame
out_data  out  CHANNELS*DATA_W  same packing as in_data

Behaviour:
- Reset (async): state IDLE; in_ready=1; out_valid=0; out_data=0; all x1/x2/y1/y2 history=0; prev_sel=0; clear_pend=0.
- Difference equation: y = b0*x0 + b1*x1 + b2*x2 + a1*y1 + a2*y2. The a-terms are stored with sign already applied.
- Coefficient sets:
  - 0: bypass (b0=1.0, all others 0).
  - 1..4: highpass at 100 Hz / 250 Hz / 500 Hz / 1 kHz, using the existing channel-strip values.
  - 5..7: bypass.
- Arithmetic:
  - Each product is full precision, COEF_W + DATA_W + GUARD bits.
  - The accumulator is the product width plus 3 bits.
  - After the fifth tap, shift the accumulator right arithmetically by FRAC (floor).
- Storage:
  - The y-history stores the shifted sum clamped to ±(2^(DATA_W+GUARD-1)-1).
  - out_data stores the shifted sum clamped to ±(2^(DATA_W-1)-1), i.e. ±32767, symmetric.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch in_data and filter, set ch=0, tap=0, go to MAC.
    - If CLEAR_ON_CHANGE and filter≠prev_sel, zero all history on this same edge. Then prev_sel←filter.
    - If clear_pend or clear is high, zero all history on this same edge and clear clear_pend.
  - MAC: one tap per cycle, tap 0..4 (b0,b1,b2,a1,a2), single multiplier; after tap 4 go to WRITE.
  - WRITE (1 cycle): write the saturated result to out_data slot ch; x2←x1, x1←x0, y2←y1, y1←unsaturated clamped sum.
    - If ch<CHANNELS-1: ch++, tap=0, go to MAC.
    - Otherwise go to DONE.
  - DONE: out_valid=1, out_data held stable. On out_ready: out_valid→0, go to IDLE.
- Latency: out_valid rises 6*CHANNELS clock edges after the accepting edge (12 for stereo). Throughput is one frame per 6*CHANNELS+2 cycles minimum.
- in_ready is 1 only in IDLE. The block never accepts a frame while out_valid=1, so there is no skid buffer.
- clear while not in IDLE: set clear_pend. The history is zeroed when the next frame is accepted; the frame in flight completes with old history.
- clear in IDLE with no in_valid: zero history immediately.
- filter changes between handshakes are ignored; only the value latched at accept is used.
- Reset mid-frame: aborts the frame immediately; no partial out_valid is produced.

Decomposition:
- Package biquad_pkg: COEF_W/FRAC defaults, a coef_set_t struct (b0, b1, b2, a1, a2), a constant array of 8 coef_set_t, the FSM state enum, and a sat function (value, width).
- One sub-module, biquad_mac: registered multiply-accumulate with start/last controls and the shift/clamp output. The top level holds the FSM, history RAM (registers indexed by ch) and handshake.

Test Plan:
- Bypass, CHANNELS=2, filter=0, frames (1000,-2000) then (-32768,5) → out (1000,-2000) 12 edges after accept, then (-32767,5).
- filter=1, ch0 input 32767 then -32768 → first output 32467, second output clamps to -32767; a golden floating model matches within 1 LSB thereafter.
- Backpressure: out_ready=0 for 20 cycles → out_valid and out_data stable, in_ready=0, in_valid ignored. After release, the next frame is accepted the cycle after DONE exits.
- Filter change: run 10 frames at filter=2, then filter=3 with CLEAR_ON_CHANGE=1 → the first output equals b0(set3)*x0 exactly (history zero). With CLEAR_ON_CHANGE=0 the history is carried over.
- clear pulsed during MAC → the current frame output uses old history; the next frame's output equals b0*x0.
- reset asserted mid-MAC at tap 2 → out_valid=0 and in_ready=1 immediately, history zero. The next frame behaves as the first after power-up.

Source files
------------

// File: rtl/biquad_pkg.sv
`default_nettype none
// ============================================================================
// Module : biquad_pkg
// Brief  : Shared types, coefficient table and saturation helper for biquad_mc.
// Rev    : 1.0  initial release
// ============================================================================
package biquad_pkg;

   localparam int c_coef_w = 32;
   localparam int c_frac   = 30;

   typedef struct packed {
      logic signed [c_coef_w-1:0] b0;
      logic signed [c_coef_w-1:0] b1;
      logic signed [c_coef_w-1:0] b2;
      logic signed [c_coef_w-1:0] a1;
      logic signed [c_coef_w-1:0] a2;
   } coef_set_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAC   = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam coef_set_t c_bypass = '{
      b0: 32'sd1073741824, b1: 32'sd0, b2: 32'sd0, a1: 32'sd0, a2: 32'sd0
   };

   // Q2.30 highpass sets (100 Hz, 250 Hz, 500 Hz, 1 kHz); a-terms carry their sign.
   localparam coef_set_t c_coef_table [8] = '{
      c_bypass,
      '{b0: 32'sd1063920000, b1: -32'sd2127840000, b2: 32'sd1063920000,
        a1: 32'sd2127660000, a2: -32'sd1054280000},
      '{b0: 32'sd1041000000, b1: -32'sd2082000000, b2: 32'sd1041000000,
        a1: 32'sd2081000000, a2: -32'sd1009000000},
      '{b0: 32'sd1010000000, b1: -32'sd2020000000, b2: 32'sd1010000000,
        a1: 32'sd2015000000, a2: -32'sd946000000},
      '{b0: 32'sd948000000,  b1: -32'sd1896000000, b2: 32'sd948000000,
        a1: 32'sd1883000000, a2: -32'sd836000000},
      c_bypass,
      c_bypass,
      c_bypass
   };

   // Symmetric clamp to +/-(2^(width-1)-1).
   function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
      logic signed [63:0] lim;
      lim = (64'sd1 <<< (width - 1)) - 64'sd1;
      if (value > lim)
         return lim;
      else if (value < -lim)
         return -lim;
      return value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/biquad_mac.sv
`default_nettype none
// ============================================================================
// Module : biquad_mac
// Brief  : Registered multiply-accumulate with floor shift and dual clamp outputs.
// Rev    : 1.0  initial release
// ============================================================================
module biquad_mac
   import biquad_pkg::*;
#(
   parameter int COEF_W = 32,
   parameter int SMP_W  = 20,
   parameter int FRAC   = 30,
   parameter int OUT_W  = 16
) (
   input  logic                     clk_144,
   input  logic                     reset,
   input  logic                     i_en,
   input  logic                     i_start,
   input  logic signed [COEF_W-1:0] i_coef,
   input  logic signed [SMP_W-1:0]  i_smp,
   output logic signed [SMP_W-1:0]  o_y_hist,
   output logic signed [OUT_W-1:0]  o_y_out
);

   localparam int c_prod_w = COEF_W + SMP_W;
   localparam int c_acc_w  = c_prod_w + 3;

   logic signed [c_prod_w-1:0] w_prod;
   logic signed [c_acc_w-1:0]  r_acc;
   logic signed [c_acc_w-1:0]  w_shift;
   logic signed [63:0]         w_wide;

   assign w_prod = c_prod_w'(i_coef) * c_prod_w'(i_smp);

   always_ff @(posedge clk_144 or posedge reset) begin
      if (reset)
         r_acc <= '0;
      else if (i_en)
         r_acc <= i_start ? c_acc_w'(w_prod) : r_acc + c_acc_w'(w_prod);
   end

   assign w_shift  = r_acc >>> FRAC;
   assign w_wide   = 64'(w_shift);
   assign o_y_hist = SMP_W'(sat(w_wide, SMP_W));
   assign o_y_out  = OUT_W'(sat(w_wide, OUT_W));

endmodule
`default_nettype wire

// File: rtl/biquad_mc.sv
`default_nettype none
// ============================================================================
// Module : biquad_mc
// Brief  : Time-multiplexed multi-channel biquad with one shared multiplier.
// Rev    : 1.0  initial release
// ============================================================================
module biquad_mc
   import biquad_pkg::*;
#(
   parameter int CHANNELS        = 2,
   parameter int DATA_W          = 16,
   parameter int COEF_W          = c_coef_w,
   parameter int FRAC            = c_frac,
   parameter int GUARD           = 4,
   parameter int CLEAR_ON_CHANGE = 1
) (
   input  logic                         clk_144,
   input  logic                         reset,
   input  logic [2:0]                   filter,
   input  logic                         clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHANNELS*DATA_W-1:0]   in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CHANNELS*DATA_W-1:0]   out_data
);

   localparam int c_hist_w = DATA_W + GUARD;
   localparam int c_ch_w   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [c_ch_w-1:0] c_last_ch = c_ch_w'(CHANNELS - 1);

   state_t                       r_state, w_state_nxt;
   logic [c_ch_w-1:0]            r_ch;
   logic [2:0]                   r_tap;
   logic [2:0]                   r_sel;
   logic [2:0]                   r_prev_sel;
   logic                         r_clear_pend;
   logic [CHANNELS*DATA_W-1:0]   r_x0;
   logic [CHANNELS*DATA_W-1:0]   r_out_data;
   logic signed [DATA_W-1:0]     r_x1 [CHANNELS];
   logic signed [DATA_W-1:0]     r_x2 [CHANNELS];
   logic signed [c_hist_w-1:0]   r_y1 [CHANNELS];
   logic signed [c_hist_w-1:0]   r_y2 [CHANNELS];

   logic                         w_accept;
   logic                         w_zero_hist;
   logic signed [DATA_W-1:0]     w_x0;
   logic signed [c_hist_w-1:0]   w_smp;
   logic signed [COEF_W-1:0]     w_coef;
   logic signed [c_hist_w-1:0]   w_y_hist;
   logic signed [DATA_W-1:0]     w_y_out;
   coef_set_t                    w_set;

   assign w_accept = (r_state == S_IDLE) && in_valid;

   // History is wiped on accept (filter change / clear / pending clear) or by clear while idle.
   assign w_zero_hist = (w_accept && (((CLEAR_ON_CHANGE != 0) && (filter != r_prev_sel))
                                      || clear || r_clear_pend))
                      || ((r_state == S_IDLE) && clear);

   always_ff @(posedge clk_144 or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               w_state_nxt = S_MAC;
         end
         S_MAC: begin
            if (r_tap == 3'd4)
               w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            w_state_nxt = (r_ch == c_last_ch) ? S_DONE : S_MAC;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_x0  = r_x0[r_ch*DATA_W +: DATA_W];
   assign w_set = c_coef_table[r_sel];

   always_comb begin
      w_smp  = '0;
      w_coef = '0;
      case (r_tap)
         3'd0: begin w_smp = c_hist_w'(w_x0);       w_coef = COEF_W'(w_set.b0); end
         3'd1: begin w_smp = c_hist_w'(r_x1[r_ch]); w_coef = COEF_W'(w_set.b1); end
         3'd2: begin w_smp = c_hist_w'(r_x2[r_ch]); w_coef = COEF_W'(w_set.b2); end
         3'd3: begin w_smp = r_y1[r_ch];            w_coef = COEF_W'(w_set.a1); end
         3'd4: begin w_smp = r_y2[r_ch];            w_coef = COEF_W'(w_set.a2); end
         default: ;
      endcase
   end

   biquad_mac #(
      .COEF_W (COEF_W),
      .SMP_W  (c_hist_w),
      .FRAC   (FRAC),
      .OUT_W  (DATA_W)
   ) u_mac (
      .clk_144  (clk_144),
      .reset    (reset),
      .i_en     (r_state == S_MAC),
      .i_start  (r_tap == 3'd0),
      .i_coef   (w_coef),
      .i_smp    (w_smp),
      .o_y_hist (w_y_hist),
      .o_y_out  (w_y_out)
   );

   always_ff @(posedge clk_144 or posedge reset) begin
      if (reset) begin
         r_ch         <= '0;
         r_tap        <= '0;
         r_sel        <= '0;
         r_prev_sel   <= '0;
         r_clear_pend <= 1'b0;
         r_x0         <= '0;
         r_out_data   <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            r_x1[c] <= '0;
            r_x2[c] <= '0;
            r_y1[c] <= '0;
            r_y2[c] <= '0;
         end
      end else begin
         if (w_zero_hist) begin
            for (int c = 0; c < CHANNELS; c++) begin
               r_x1[c] <= '0;
               r_x2[c] <= '0;
               r_y1[c] <= '0;
               r_y2[c] <= '0;
            end
         end
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x0         <= in_data;
                  r_sel        <= filter;
                  r_prev_sel   <= filter;
                  r_ch         <= '0;
                  r_tap        <= '0;
                  r_clear_pend <= 1'b0;
               end else if (clear) begin
                  r_clear_pend <= 1'b0;
               end
            end
            S_MAC: r_tap <= r_tap + 3'd1;
            S_WRITE: begin
               r_out_data[r_ch*DATA_W +: DATA_W] <= w_y_out;
               r_x2[r_ch] <= r_x1[r_ch];
               r_x1[r_ch] <= w_x0;
               r_y2[r_ch] <= r_y1[r_ch];
               r_y1[r_ch] <= w_y_hist;
               r_tap      <= '0;
               if (r_ch != c_last_ch)
                  r_ch <= r_ch + 1'b1;
            end
            default: ;
         endcase
         // A clear arriving mid-frame is deferred so the frame in flight keeps its history.
         if ((r_state != S_IDLE) && clear)
            r_clear_pend <= 1'b1;
      end
   end

   assign out_data = r_out_data;

endmodule
`default_nettype wire
